// File: rtl/puf_race_ctrl.sv
// Arbiter-PUF controller: launch a challenge REPS times and return the majority vote plus ones count.
// Latency REPS*(SETTLE+CAPTURE+RECOVER) from accept to resp_valid; holds the response until resp_ready, one challenge in flight.
module puf_race_ctrl #(
  parameter int CW      = 16,
  parameter int SETTLE  = 4,
  parameter int CAPTURE = 4,
  parameter int RECOVER = 4,
  parameter int REPS    = 5,
  parameter int RW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] chal_in,
  input  logic          chal_valid,
  output logic          chal_ready,
  output logic [CW-1:0] c_out,
  output logic          launch,
  input  logic          arb_in,
  output logic          resp_out,
  output logic [RW-1:0] resp_ones,
  output logic          resp_valid,
  input  logic          resp_ready
);

  localparam int PMAX12 = (SETTLE > CAPTURE) ? SETTLE : CAPTURE;
  localparam int PMAX   = (PMAX12 > RECOVER) ? PMAX12 : RECOVER;
  localparam int PW     = (PMAX > 1) ? $clog2(PMAX) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StFire,
    StRecover,
    StDone
  } stateT;

  stateT         state;
  stateT         stateNext;
  logic [PW-1:0] phaseCnt;
  logic [7:0]    repCnt;
  logic [RW-1:0] onesCnt;
  logic          arbMeta;
  logic          arbSync;
  logic          phaseEnd;
  logic          lastRep;
  logic [RW:0]   twiceOnes;

  assign chal_ready = (state == StIdle) && !rst;
  assign resp_valid = (state == StDone);
  assign lastRep    = (int'(repCnt) + 1) >= REPS;
  assign twiceOnes  = {onesCnt, 1'b0};

  always_comb begin
    stateNext = state;
    phaseEnd  = 1'b0;
    case (state)
      StIdle: begin
        if (chal_valid) stateNext = StSettle;
      end
      StSettle: begin
        phaseEnd = (phaseCnt == PW'(SETTLE - 1));
        if (phaseEnd) stateNext = StFire;
      end
      StFire: begin
        phaseEnd = (phaseCnt == PW'(CAPTURE - 1));
        if (phaseEnd) stateNext = StRecover;
      end
      StRecover: begin
        phaseEnd = (phaseCnt == PW'(RECOVER - 1));
        if (phaseEnd) stateNext = lastRep ? StDone : StSettle;
      end
      StDone: begin
        if (resp_ready) stateNext = StIdle;
      end
      default: stateNext = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      phaseCnt  <= '0;
      repCnt    <= '0;
      onesCnt   <= '0;
      arbMeta   <= 1'b0;
      arbSync   <= 1'b0;
      c_out     <= '0;
      launch    <= 1'b0;
      resp_out  <= 1'b0;
      resp_ones <= '0;
    end else begin
      state   <= stateNext;
      arbMeta <= arb_in;
      arbSync <= arbMeta;
      // launch is registered, so it tracks the state being entered
      launch  <= (stateNext == StFire);
      phaseCnt <= (stateNext != state) ? '0 : phaseCnt + PW'(1);

      if (state == StIdle && chal_valid) begin
        c_out   <= chal_in;
        repCnt  <= '0;
        onesCnt <= '0;
      end

      // the arbiter is only trusted at the end of the capture window
      if (state == StFire && phaseEnd && arbSync && onesCnt != '1)
        onesCnt <= onesCnt + RW'(1);

      if (state == StRecover && phaseEnd) begin
        if (lastRep) begin
          resp_ones <= onesCnt;
          resp_out  <= twiceOnes > (RW + 1)'(REPS);
        end else begin
          repCnt <= repCnt + 8'd1;
        end
      end
    end
  end

endmodule
